// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals shared by the memory port arbiter.
// The arbiter is the slave; requesters and the memory model sit on the master side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [31:0]           i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [1:0]            d_size;
  logic                  d_lock;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [31:0]           d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [31:0]           d_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [ADDR_WIDTH-1:0] mem_next_addr;
  logic [31:0]           mem_wdata;
  logic [1:0]            mem_size;
  logic                  mem_we;
  logic [31:0]           mem_rdata;

  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_lock, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_next_addr, mem_wdata, mem_size, mem_we
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_lock, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_next_addr, mem_wdata, mem_size, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported data memory between instruction fetch and load/store, with
// fetch anti-starvation, locked D sequences and in-order routing of registered read data.
module mem_port_arbiter #(
  parameter int unsigned MAX_STARVE = 3,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  input logic              clk_enable,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned CntW = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
  localparam logic [CntW-1:0] StarveMax = CntW'(MAX_STARVE);

  logic            en;
  logic            i_gnt, d_gnt;
  logic            starve_hit;
  logic [1:0]      d_size_eff;
  logic            lock_q, lock_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic            pend_q, pend_d;
  logic            owner_q, owner_d;  // 1 = D issued the pending read

  assign en         = clk_enable & ~rst;
  assign starve_hit = (starve_q == StarveMax) & bus.i_req;
  assign d_size_eff = (bus.d_size == 2'd3) ? 2'd2 : bus.d_size;

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (en) begin
      if (lock_q) begin
        // A held lock yields to fetch only when D has nothing to issue.
        if (bus.d_req)      d_gnt = 1'b1;
        else if (bus.i_req) i_gnt = 1'b1;
      end else if (starve_hit) begin
        i_gnt = 1'b1;
      end else if (bus.d_req) begin
        d_gnt = 1'b1;
      end else if (bus.i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    bus.mem_addr  = bus.d_addr;
    bus.mem_wdata = bus.d_wdata;
    bus.mem_size  = d_size_eff;
    bus.mem_we    = d_gnt & bus.d_we;
    if (i_gnt) begin
      bus.mem_addr = bus.i_addr;
      bus.mem_size = 2'd2;
    end
  end

  assign bus.mem_next_addr = bus.mem_addr + ADDR_WIDTH'(4);
  assign bus.i_gnt         = i_gnt;
  assign bus.d_gnt         = d_gnt;
  assign bus.i_rvalid      = pend_q & ~owner_q & ~rst;
  assign bus.d_rvalid      = pend_q & owner_q & ~rst;
  assign bus.i_rdata       = bus.mem_rdata;
  assign bus.d_rdata       = bus.mem_rdata;

  always_comb begin
    lock_d   = lock_q;
    starve_d = starve_q;
    pend_d   = pend_q;
    owner_d  = owner_q;
    if (en) begin
      pend_d  = i_gnt | (d_gnt & ~bus.d_we);
      owner_d = d_gnt;

      if (d_gnt)           lock_d = bus.d_lock;
      else if (!bus.d_req) lock_d = 1'b0;

      if (i_gnt || !bus.i_req)     starve_d = '0;
      else if (starve_q != StarveMax) starve_d = starve_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q   <= 1'b0;
      starve_q <= '0;
      pend_q   <= 1'b0;
      owner_q  <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      starve_q <= starve_d;
      pend_q   <= pend_d;
      owner_q  <= owner_d;
    end
  end
endmodule
